// File: rtl/int8_mac_feeder_if.sv
// int8_mac_feeder_if -- bundles the control, operand stream, MAC-side and
// result signals of int8_mac_feeder.
//   slave  : the feeder itself (consumes start/operands/MAC result, drives the rest)
//   master : the environment (controller, operand source, MAC, result sink)
// With INT8_MAC_FEEDER_SAT_EN defined, the bundle also carries res_ovf.
interface int8_mac_feeder_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_tiles;
  logic             busy;
  // operand word stream
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  // MAC side
  logic             mac_int8_en;
  logic [263:0]     mac_a_vec;
  logic [263:0]     mac_b_vec;
  logic [23:0]      mac_psum_in;
  logic [23:0]      mac_psum_out;
  // result stream
  logic             res_valid;
  logic             res_ready;
  logic [23:0]      res_data;
`ifdef INT8_MAC_FEEDER_SAT_EN
  logic             res_ovf;

  modport slave (
    input  start, num_tiles, in_valid, in_a, in_b, mac_psum_out, res_ready,
    output busy, in_ready, mac_int8_en, mac_a_vec, mac_b_vec, mac_psum_in,
           res_valid, res_data, res_ovf
  );
  modport master (
    output start, num_tiles, in_valid, in_a, in_b, mac_psum_out, res_ready,
    input  busy, in_ready, mac_int8_en, mac_a_vec, mac_b_vec, mac_psum_in,
           res_valid, res_data, res_ovf
  );
`else
  modport slave (
    input  start, num_tiles, in_valid, in_a, in_b, mac_psum_out, res_ready,
    output busy, in_ready, mac_int8_en, mac_a_vec, mac_b_vec, mac_psum_in,
           res_valid, res_data
  );
  modport master (
    output start, num_tiles, in_valid, in_a, in_b, mac_psum_out, res_ready,
    input  busy, in_ready, mac_int8_en, mac_a_vec, mac_b_vec, mac_psum_in,
           res_valid, res_data
  );
`endif
endinterface

// File: rtl/int8_mac_feeder.sv
// int8_mac_feeder -- operand sequencer and accumulator for the 32-lane int8 MAC.
// Packs 8 operand words (4 A bytes + 4 B bytes each) into one 32-lane tile,
// pulses the MAC once per tile with the running partial sum, captures the
// MAC's registered result one cycle later, and after the programmed number of
// tiles offers the 24-bit dot product on the result handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : int8_mac_feeder_if.slave
//                start/num_tiles/busy         control
//                in_valid/in_ready/in_a/in_b  operand word stream
//                mac_*                        MAC tile, enable and partial sums
//                res_valid/res_ready/res_data result stream
// Build option: define INT8_MAC_FEEDER_SAT_EN to saturate the accumulator at
// 24'hFFFFFF on wrap and report a sticky res_ovf; otherwise sums wrap mod 2^24.
module int8_mac_feeder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  int8_mac_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             word_cnt;
  logic [CNT_W-1:0]       tile_cnt;
  logic [CNT_W-1:0]       tile_max;
  logic [23:0]            acc;
  logic [7:0][31:0]       a_buf;   // word w -> lanes 4w..4w+3
  logic [7:0][31:0]       b_buf;
  logic                   last_tile;
`ifdef INT8_MAC_FEEDER_SAT_EN
  logic                   ovf;
`endif

  assign last_tile = (tile_cnt == tile_max - CNT_W'(1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake/control outputs
  always_comb begin
    state_nxt       = state;
    bus.in_ready    = 1'b0;
    bus.mac_int8_en = 1'b0;
    bus.res_valid   = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && word_cnt == 3'd7) state_nxt = FIRE;
      end
      FIRE: begin
        bus.mac_int8_en = 1'b1;
        state_nxt       = WAIT;
      end
      WAIT: state_nxt = last_tile ? DONE : LOAD;
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: tile buffers, counters, accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      tile_cnt <= '0;
      tile_max <= '0;
      acc      <= '0;
      a_buf    <= '0;
      b_buf    <= '0;
`ifdef INT8_MAC_FEEDER_SAT_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          tile_max <= (bus.num_tiles == '0) ? CNT_W'(1) : bus.num_tiles;
          word_cnt <= '0;
          tile_cnt <= '0;
          acc      <= '0;
`ifdef INT8_MAC_FEEDER_SAT_EN
          ovf      <= 1'b0;
`endif
        end
        LOAD: if (bus.in_valid) begin
          a_buf[word_cnt] <= bus.in_a;
          b_buf[word_cnt] <= bus.in_b;
          word_cnt        <= word_cnt + 3'd1;  // 3 bits: wraps to 0 after beat 7
        end
        WAIT: begin
`ifdef INT8_MAC_FEEDER_SAT_EN
          // products are non-negative, so a smaller result means the sum wrapped
          if (ovf || bus.mac_psum_out < acc) begin
            acc <= 24'hFF_FFFF;
            ovf <= 1'b1;
          end else begin
            acc <= bus.mac_psum_out;
          end
`else
          acc <= bus.mac_psum_out;
`endif
          if (!last_tile) tile_cnt <= tile_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.mac_a_vec   = {8'h00, a_buf};
  assign bus.mac_b_vec   = {8'h00, b_buf};
  assign bus.mac_psum_in = acc;
  assign bus.res_data    = acc;   // only leaves acc in WAIT, so stable in DONE
`ifdef INT8_MAC_FEEDER_SAT_EN
  assign bus.res_ovf     = ovf;
`endif

endmodule

// File: tb/tb_int8_mac_feeder.sv
// tb_int8_mac_feeder -- directed bench for int8_mac_feeder with a behavioural
// 1-cycle-latency MAC and hand-computed expected dot products.
module tb_int8_mac_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int8_mac_feeder_if bus ();

  int8_mac_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // external MAC: registered, psum_out = psum_in + sum(a_k*b_k) mod 2^24
  function automatic logic [23:0] dot32(input logic [263:0] a, input logic [263:0] b);
    logic [23:0] s;
    s = '0;
    for (int k = 0; k < 32; k++) s = s + 24'(a[8*k +: 8] * b[8*k +: 8]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               bus.mac_psum_out <= '0;
    else if (bus.mac_int8_en) bus.mac_psum_out <= bus.mac_psum_in + dot32(bus.mac_a_vec, bus.mac_b_vec);
  end

  // pulse log: counters only grow, tests take a base index
  int          pulses = 0;
  int          rdy_in_fire = 0;
  logic [7:0]  hi_or = '0;
  logic [23:0] psum_log [64];
  always @(posedge clk) begin
    if (bus.mac_int8_en) begin
      if (pulses < 64) psum_log[pulses] <= bus.mac_psum_in;
      pulses <= pulses + 1;
      hi_or  <= hi_or | bus.mac_a_vec[263:256] | bus.mac_b_vec[263:256];
      if (bus.in_ready) rdy_in_fire <= rdy_in_fire + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] n);
    bus.start     = 1'b1;
    bus.num_tiles = n;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // lane_mode: lane k gets A byte k; otherwise every byte is av/bv
  task automatic send_tile(input logic [7:0] av, input logic [7:0] bv, input bit lane_mode,
                           input bit gaps, input int nbeats);
    logic [31:0] a;
    for (int w = 0; w < nbeats; w++) begin
      if (gaps) repeat ((w * 5 + 1) % 3) tick();
      a = lane_mode ? {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)} : {4{av}};
      send_beat(a, {4{bv}});
    end
  endtask

  task automatic wait_res(input string tag);
    int waited;
    waited = 0;
    while (!bus.res_valid && waited < 50) begin
      tick();
      waited++;
    end
    chk(tag, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic accept_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  int base;

  initial begin
    bus.start     = 1'b0;
    bus.num_tiles = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_mac_en", 32'(bus.mac_int8_en), 0);
    rst_n = 1'b1;
    tick();

    // 1: one tile of 1*2 -> 64
    base = pulses;
    start_op(8'd1);
    chk("t1_busy", 32'(bus.busy), 1);
    send_tile(8'h01, 8'h02, 1'b0, 1'b0, 8);
    wait_res("t1_valid");
    chk("t1_pulses", 32'(pulses - base), 1);
    chk("t1_psum0", 32'(psum_log[base]), 0);
    chk("t1_res", 32'(bus.res_data), 64);
    accept_res();
    chk("t1_valid_drop", 32'(bus.res_valid), 0);

    // 2: three tiles of 0xFF*0xFF
    base = pulses;
    start_op(8'd3);
    for (int t = 0; t < 3; t++) send_tile(8'hFF, 8'hFF, 1'b0, 1'b0, 8);
    wait_res("t2_valid");
    chk("t2_pulses", 32'(pulses - base), 3);
    chk("t2_psum0", 32'(psum_log[base]), 0);
    chk("t2_psum1", 32'(psum_log[base+1]), 2080800);
    chk("t2_psum2", 32'(psum_log[base+2]), 4161600);
    chk("t2_res", 32'(bus.res_data), 6242400);
    accept_res();

    // 3: num_tiles=0 acts as 1; A lane k = k, B = 1 -> 496
    base = pulses;
    start_op(8'd0);
    send_tile(8'h00, 8'h01, 1'b1, 1'b0, 8);
    wait_res("t3_valid");
    chk("t3_pulses", 32'(pulses - base), 1);
    chk("t3_res", 32'(bus.res_data), 496);
    chk("t3_pad_bits", 32'(hi_or), 0);
    accept_res();

    // 4: two tiles with input gaps, result held under backpressure
    start_op(8'd2);
    for (int t = 0; t < 2; t++) send_tile(8'h01, 8'h01, 1'b0, 1'b1, 8);
    wait_res("t4_valid");
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", 32'(bus.res_valid), 1);
      chk("t4_hold_data", 32'(bus.res_data), 64);
      chk("t4_rdy_done", 32'(bus.in_ready), 0);
      tick();
    end
    accept_res();
    chk("t4_valid_drop", 32'(bus.res_valid), 0);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_rdy_idle", 32'(bus.in_ready), 0);
    chk("t4_rdy_in_fire", 32'(rdy_in_fire), 0);

    // 5: asynchronous reset after beat 4 of tile 2
    base = pulses;
    start_op(8'd3);
    send_tile(8'h07, 8'h09, 1'b0, 1'b0, 8);
    send_tile(8'h07, 8'h09, 1'b0, 1'b0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_in_ready", 32'(bus.in_ready), 0);
    chk("t5_a_vec", 32'(|bus.mac_a_vec), 0);
    chk("t5_b_vec", 32'(|bus.mac_b_vec), 0);
    chk("t5_psum_in", 32'(bus.mac_psum_in), 0);
    chk("t5_res_data", 32'(bus.res_data), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("t5_pulses", 32'(pulses - base), 1);
    start_op(8'd1);
    send_tile(8'h01, 8'h01, 1'b0, 1'b0, 8);
    wait_res("t5_valid");
    chk("t5_res", 32'(bus.res_data), 32);
    accept_res();

    // 6: nine full tiles overflow 24 bits
    start_op(8'd9);
    for (int t = 0; t < 9; t++) send_tile(8'hFF, 8'hFF, 1'b0, 1'b0, 8);
    wait_res("t6_valid");
`ifdef INT8_MAC_FEEDER_SAT_EN
    chk("t6_res_sat", 32'(bus.res_data), 32'hFF_FFFF);
    chk("t6_ovf", 32'(bus.res_ovf), 1);
    accept_res();
    start_op(8'd1);
    chk("t6_ovf_clr", 32'(bus.res_ovf), 0);
    send_tile(8'h01, 8'h01, 1'b0, 1'b0, 8);
    wait_res("t6b_valid");
    chk("t6b_res", 32'(bus.res_data), 32);
`else
    chk("t6_res_wrap", 32'(bus.res_data), 1949984);
`endif
    accept_res();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
